frame_pingpong_buffer: RTL and testbench

//  Upstream input stage of GarbageSortTop. Captures one 32x32 RGB888 frame from a camera-side pixel

---
 rtl/frame_pingpong_buffer.sv | 149 ++++++++++++++
 tb/tb_frame_pingpong_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pingpong_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_pingpong_buffer : two-bank frame capture with network read port    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module frame_pingpong_buffer #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 10,
  parameter int START_HOLD = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pix_valid,
  input  logic              i_pix_sof,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_pix_ready,
  input  logic [ADDR_W-1:0] i_read_addr,
  output logic [DATA_W-1:0] o_d_out,
  output logic              o_conv_start,
  input  logic              i_net_complete,
  output logic              o_frame_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(START_HOLD - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_FULL = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_BUSY  = 2'd2
  } rd_state_t;

  wr_state_t         r_wr_state, w_wr_state_nxt;
  rd_state_t         r_rd_state, w_rd_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt, w_wr_idx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_wr_bank, r_rd_bank;
  logic              r_pix_ready, r_conv_start, r_frame_err;
  logic [DATA_W-1:0] r_d_out;
  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
  logic              w_xfer, w_swap, w_wr_en, w_restart;

  assign w_xfer = i_pix_valid && r_pix_ready;
  // A completing network frees the read side in the same cycle it finishes.
  assign w_swap = (r_wr_state == W_FULL) && ((r_rd_state == R_IDLE) || i_net_complete);

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_idx       = r_wr_addr;
    w_wr_en        = 1'b0;
    w_restart      = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_xfer && i_pix_sof) begin
          w_wr_en        = 1'b1;
          w_wr_idx       = '0;
          w_wr_addr_nxt  = ADDR_W'(1);
          w_wr_state_nxt = W_FILL;
        end
      end
      W_FILL: begin
        if (w_xfer) begin
          w_wr_en = 1'b1;
          if (i_pix_sof) begin
            w_wr_idx      = '0;
            w_wr_addr_nxt = ADDR_W'(1);
            w_restart     = 1'b1;
          end else begin
            w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
            if (&r_wr_addr) w_wr_state_nxt = W_FULL;
          end
        end
      end
      W_FULL: begin
        if (w_swap) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_cnt_nxt      = r_cnt;
    case (r_rd_state)
      R_IDLE: w_rd_state_nxt = R_IDLE;
      R_START: begin
        if (i_net_complete)          w_rd_state_nxt = R_IDLE;
        else if (r_cnt == C_HOLD_LAST) w_rd_state_nxt = R_BUSY;
        else                           w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      R_BUSY: begin
        if (i_net_complete) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
    if (w_swap) begin
      w_rd_state_nxt = R_START;
      w_cnt_nxt      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_state   <= W_IDLE;
      r_rd_state   <= R_IDLE;
      r_wr_addr    <= '0;
      r_cnt        <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_conv_start <= 1'b0;
      r_frame_err  <= 1'b0;
      r_d_out      <= '0;
    end else begin
      r_wr_state   <= w_wr_state_nxt;
      r_rd_state   <= w_rd_state_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_swap) begin
        r_rd_bank <= r_wr_bank;
        r_wr_bank <= ~r_wr_bank;
      end
      r_pix_ready  <= (w_wr_state_nxt != W_FULL);
      r_conv_start <= (w_rd_state_nxt == R_START);
      r_frame_err  <= w_restart;
      // Reads the pre-swap bank during the swap cycle.
      r_d_out      <= r_mem[{r_rd_bank, i_read_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_wr_en) r_mem[{r_wr_bank, w_wr_idx}] <= i_pix_data;
  end

  assign o_pix_ready  = r_pix_ready;
  assign o_conv_start = r_conv_start;
  assign o_frame_err  = r_frame_err;
  assign o_d_out      = r_d_out;

endmodule
`default_nettype wire

// File: tb/tb_frame_pingpong_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_pingpong_buffer : scoreboard bench for frame_pingpong_buffer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_frame_pingpong_buffer;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 10;
  localparam int HOLD   = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              net_complete = 1'b0;
  logic [DATA_W-1:0] pix_data = '0;
  logic [ADDR_W-1:0] read_addr = '0;
  logic              pix_ready, conv_start, frame_err;
  logic [DATA_W-1:0] d_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int val; } rd_exp_t;
  typedef struct { int cyc; bit pr; bit cs; bit fe; bit chk_d; int d; } st_exp_t;

  rd_exp_t q_rd[$];
  st_exp_t q_st[$];
  int      q_start[$];
  int      q_len[$];
  int      q_ferr[$];

  frame_pingpong_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .START_HOLD(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pix_valid   (pix_valid),
    .i_pix_sof     (pix_sof),
    .i_pix_data    (pix_data),
    .o_pix_ready   (pix_ready),
    .i_read_addr   (read_addr),
    .o_d_out       (d_out),
    .o_conv_start  (conv_start),
    .i_net_complete(net_complete),
    .o_frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations when their cycle arrives or an output event occurs.
  rd_exp_t me;
  st_exp_t ms;
  int      mv;
  int      rise_cyc = 0;
  bit      prev_cs = 1'b0;

  always @(negedge clk) begin
    if (q_rd.size() > 0 && q_rd[0].cyc <= cyc) begin
      me = q_rd.pop_front();
      checks++;
      if (me.cyc != cyc || d_out !== DATA_W'(me.val)) begin
        errors++;
        $display("FAIL d_out cyc=%0d got=%0d expected=%0d due=%0d", cyc, d_out, me.val, me.cyc);
      end
    end
    if (q_st.size() > 0 && q_st[0].cyc <= cyc) begin
      ms = q_st.pop_front();
      checks++;
      if (ms.cyc != cyc || pix_ready !== ms.pr || conv_start !== ms.cs || frame_err !== ms.fe ||
          (ms.chk_d && d_out !== DATA_W'(ms.d))) begin
        errors++;
        $display("FAIL status cyc=%0d got pr=%b cs=%b fe=%b d=%0d expected pr=%b cs=%b fe=%b d=%0d",
                 cyc, pix_ready, conv_start, frame_err, d_out, ms.pr, ms.cs, ms.fe, ms.d);
      end
    end
    if (conv_start === 1'b1 && !prev_cs) begin
      checks++;
      rise_cyc = cyc;
      if (q_start.size() == 0) begin
        errors++;
        $display("FAIL conv_start_rise unexpected at cyc=%0d", cyc);
      end else begin
        mv = q_start.pop_front();
        if (mv != cyc) begin
          errors++;
          $display("FAIL conv_start_rise got cyc=%0d expected cyc=%0d", cyc, mv);
        end
      end
    end else if (q_start.size() > 0 && q_start[0] < cyc) begin
      mv = q_start.pop_front();
      checks++;
      errors++;
      $display("FAIL conv_start_rise missing, expected cyc=%0d now=%0d", mv, cyc);
    end
    if (conv_start !== 1'b1 && prev_cs) begin
      checks++;
      if (q_len.size() == 0) begin
        errors++;
        $display("FAIL conv_start_len unexpected fall at cyc=%0d", cyc);
      end else begin
        mv = q_len.pop_front();
        if (cyc - rise_cyc != mv) begin
          errors++;
          $display("FAIL conv_start_len got=%0d expected=%0d", cyc - rise_cyc, mv);
        end
      end
    end
    prev_cs = (conv_start === 1'b1);
    if (frame_err === 1'b1) begin
      checks++;
      if (q_ferr.size() == 0) begin
        errors++;
        $display("FAIL frame_err unexpected at cyc=%0d", cyc);
      end else begin
        mv = q_ferr.pop_front();
        if (mv != cyc) begin
          errors++;
          $display("FAIL frame_err got cyc=%0d expected cyc=%0d", cyc, mv);
        end
      end
    end else if (q_ferr.size() > 0 && q_ferr[0] < cyc) begin
      mv = q_ferr.pop_front();
      checks++;
      errors++;
      $display("FAIL frame_err missing, expected cyc=%0d", mv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(input int off, input bit pr, input bit cs, input bit fe,
                        input bit chk_d, input int d);
    st_exp_t s;
    s.cyc = cyc + off; s.pr = pr; s.cs = cs; s.fe = fe; s.chk_d = chk_d; s.d = d;
    q_st.push_back(s);
  endtask

  task automatic do_read(input int addr, input int val);
    rd_exp_t r;
    read_addr = ADDR_W'(addr);
    r.cyc = cyc + 1;
    r.val = val;
    q_rd.push_back(r);
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (pix_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL pix_ready_timeout got=%b expected=1", pix_ready);
    end
  endtask

  task automatic stream(input int base, input int n, input bit sof_first, input bit nc_last);
    for (int i = 0; i < n; i++) begin
      wait_ready();
      pix_valid    = 1'b1;
      pix_sof      = sof_first && (i == 0);
      pix_data     = DATA_W'(base + i);
      net_complete = nc_last && (i == n - 1);
      tick();
    end
    pix_valid    = 1'b0;
    pix_sof      = 1'b0;
    net_complete = 1'b0;
  endtask

  task automatic pulse_nc();
    net_complete = 1'b1;
    tick();
    net_complete = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int base_t;

  initial begin
    // Reset state
    rst = 1'b0;
    tick(); exp_st(0, 0, 0, 0, 1, 0);
    tick(); exp_st(0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    tick(); exp_st(0, 1, 0, 0, 0, 0);

    // Frame 1: data = addr
    stream(0, 1024, 1, 0);
    exp_st(0, 0, 0, 0, 0, 0);
    exp_st(1, 1, 1, 0, 0, 0);
    q_start.push_back(cyc + 1); q_len.push_back(HOLD);
    tick();
    do_read(5, 5); do_read(0, 0); do_read(1023, 1023);

    // Frame 2 fills while frame 1 is being read
    stream(1000, 1024, 1, 0);
    exp_st(0, 0, 0, 0, 0, 0);
    do_read(5, 5);
    exp_st(0, 0, 0, 0, 0, 0);
    q_start.push_back(cyc + 1); q_len.push_back(HOLD);
    pulse_nc();
    exp_st(0, 1, 1, 0, 0, 0);
    do_read(5, 1005); do_read(1023, 2023);

    // Release the read side, then a frame restarted mid-way
    repeat (HOLD + 5) tick();
    pulse_nc();
    stream(3000, 300, 1, 0);
    stream(5000, 1, 1, 0);
    q_ferr.push_back(cyc);
    stream(5001, 1023, 0, 0);
    exp_st(0, 0, 0, 0, 0, 0);
    base_t = cyc;
    q_start.push_back(base_t + 1); q_len.push_back(39);
    tick();
    do_read(0, 5000); do_read(299, 5299); do_read(1023, 6023);

    // Early net_complete during the start strobe
    wait_until(base_t + 39);
    pulse_nc();
    exp_st(0, 1, 0, 0, 0, 0);
    stream(7000, 1024, 1, 0);
    base_t = cyc;
    q_start.push_back(base_t + 1); q_len.push_back(50);
    tick();
    do_read(5, 7005);

    // Reset in the middle of the start strobe
    wait_until(base_t + 50);
    rst = 1'b0;
    tick(); exp_st(0, 0, 0, 0, 1, 0);
    tick(); exp_st(0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    tick(); exp_st(0, 1, 0, 0, 0, 0);
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = DATA_W'(9999);
    tick();
    pix_valid = 1'b0;
    stream(8000, 1024, 1, 0);
    q_start.push_back(cyc + 1); q_len.push_back(HOLD);
    tick();
    do_read(0, 8000); do_read(1023, 9023);

    // Last pixel coincides with net_complete
    stream(10000, 1024, 1, 1);
    exp_st(0, 0, 0, 0, 0, 0);
    q_start.push_back(cyc + 1); q_len.push_back(HOLD);
    tick();
    do_read(5, 10005); do_read(1023, 11023);
    repeat (HOLD + 10) tick();

    foreach (q_rd[i])    begin checks++; errors++; $display("FAIL leftover d_out due=%0d", q_rd[i].cyc); end
    foreach (q_st[i])    begin checks++; errors++; $display("FAIL leftover status due=%0d", q_st[i].cyc); end
    foreach (q_start[i]) begin checks++; errors++; $display("FAIL leftover conv_start_rise due=%0d", q_start[i]); end
    foreach (q_len[i])   begin checks++; errors++; $display("FAIL leftover conv_start_len=%0d", q_len[i]); end
    foreach (q_ferr[i])  begin checks++; errors++; $display("FAIL leftover frame_err due=%0d", q_ferr[i]); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
